// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared 32x32 single-port data memory.
// Each grant runs IDLE -> ACCESS (memory driven for one cycle) -> ACK (one-cycle pulse).
module data_mem_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate pending requests
  // ACCESS | memory driven from latched request; read data captured
  // ACK    | ack (and err) pulse to the winner; grant released on exit
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic        win1;
  logic        aligned;
  logic        owner1;

  // Port 1 wins when alone, or on a round-robin tie when port 0 had the last grant.
  assign win1    = req1 & (~req0 | ((FIXED_PRIORITY == 1'b0) & ~last_grant_q));
  assign aligned = (addr_q[1:0] == 2'b00);
  assign owner1  = grant_q[1];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d      = ACCESS;
          grant_d      = win1 ? 2'b10 : 2'b01;
          last_grant_d = win1;
          we_d         = win1 ? we1 : we0;
          addr_d       = win1 ? addr1 : addr0;
          wdata_d      = win1 ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = ACK;
        ack0_d  = ~owner1;
        ack1_d  = owner1;
        if (!aligned) begin
          if (owner1) begin
            rdata1_d = '0;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = '0;
            err0_d   = 1'b1;
          end
        end else if (!we_q) begin
          if (owner1) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  // Reset gates the write strobe directly so an access cut by reset never commits.
  assign mem_rw    = (state_q == ACCESS) & we_q & aligned & ~Reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random two-port traffic,
// checked every cycle against a transaction-schedule model of the arbiter and memory.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        preload;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];

  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        ack0, ack1, err0, err1, busy, mem_rw;
  logic [1:0]  grant;

  logic [31:0] rdata0_f, rdata1_f, mem_addr_f, mem_wdata_f, mem_rdata_f;
  logic        ack0_f, ack1_f, err0_f, err1_f, busy_f, mem_rw_f;
  logic [1:0]  grant_f;

  logic [31:0] mem   [32];
  logic [31:0] mem_f [32];

  always #5 Clock = ~Clock;

  data_mem_arbiter #(.FIXED_PRIORITY(1'b0)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.FIXED_PRIORITY(1'b1)) u_fix (
    .Clock(Clock), .Reset(Reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .rdata0(rdata0_f), .rdata1(rdata1_f), .ack0(ack0_f), .ack1(ack1_f),
    .err0(err0_f), .err1(err1_f), .grant(grant_f), .busy(busy_f),
    .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rw(mem_rw_f), .mem_rdata(mem_rdata_f)
  );

  assign mem_rdata   = mem[mem_addr[6:2]];
  assign mem_rdata_f = mem_f[mem_addr_f[6:2]];

  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]   <= 32'(i * i);
        mem_f[i] <= 32'(i * i);
      end
    end else begin
      if (mem_rw)   mem[mem_addr[6:2]]     <= mem_wdata;
      if (mem_rw_f) mem_f[mem_addr_f[6:2]] <= mem_wdata_f;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: an access accepted at edge e occupies cycle e (memory driven)
  // and cycle e+1 (ack); the next request can be accepted at edge e+3.
  int          acc_edge = -100;
  int          m_w = 0;
  bit          m_lg = 1'b1;
  logic        m_we = 1'b0;
  logic [31:0] m_maddr = '0, m_mwdata = '0;
  logic [31:0] m_rdata [2];
  logic [31:0] m_mem   [32];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int e;
    e = cyc + 1;
    if (Reset) begin
      acc_edge   = -100;
      m_lg       = 1'b1;
      m_w        = 0;
      m_we       = 1'b0;
      m_maddr    = '0;
      m_mwdata   = '0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      return;
    end
    if (e == acc_edge + 1) begin
      if (m_maddr[1:0] != 2'b00) m_rdata[m_w] = '0;
      else if (m_we)             m_mem[m_maddr[6:2]] = m_mwdata;
      else                       m_rdata[m_w] = m_mem[m_maddr[6:2]];
    end
    if (e >= acc_edge + 3 && (req[0] || req[1])) begin
      if (req[0] && req[1]) m_w = m_lg ? 0 : 1;
      else                  m_w = req[1] ? 1 : 0;
      m_lg     = (m_w == 1);
      m_we     = we[m_w];
      m_maddr  = addr[m_w];
      m_mwdata = wdata[m_w];
      acc_edge = e;
    end
  endtask

  task automatic check_outputs();
    bit acc, ak, al;
    logic [1:0] eg;
    acc = (cyc == acc_edge);
    ak  = (cyc == acc_edge + 1);
    al  = (m_maddr[1:0] == 2'b00);
    eg  = (acc || ak) ? ((m_w == 1) ? 2'b10 : 2'b01) : 2'b00;
    check_val("grant",     {30'd0, grant},  {30'd0, eg});
    check_val("busy",      {31'd0, busy},   {31'd0, (acc || ak)});
    check_val("mem_rw",    {31'd0, mem_rw}, {31'd0, (acc && m_we && al && !Reset)});
    check_val("ack0",      {31'd0, ack0},   {31'd0, (ak && m_w == 0)});
    check_val("ack1",      {31'd0, ack1},   {31'd0, (ak && m_w == 1)});
    check_val("err0",      {31'd0, err0},   {31'd0, (ak && m_w == 0 && !al)});
    check_val("err1",      {31'd0, err1},   {31'd0, (ak && m_w == 1 && !al)});
    check_val("rdata0",    rdata0,    m_rdata[0]);
    check_val("rdata1",    rdata1,    m_rdata[1]);
    check_val("mem_addr",  mem_addr,  m_maddr);
    check_val("mem_wdata", mem_wdata, m_mwdata);
  endtask

  task automatic tick();
    @(negedge Clock);
    check_outputs();
    model_edge();
    @(posedge Clock);
    cyc++;
    #1;
  endtask

  // Raise a request and wait (bounded) for its ack; leaves the bench in the ack cycle.
  task automatic do_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int lat;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      lat++;
      if ((p == 0) ? ack0 : ack1) break;
    end
    check_val("ack_latency", lat, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, n0, n1, seen;
    bit drop_nxt [2];
    logic ackp;
    Reset = 1'b1; preload = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    drop_nxt[0] = 1'b0; drop_nxt[1] = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'(i * i);
    repeat (2) @(posedge Clock);
    #1;
    preload = 1'b0;
    Reset = 1'b0;

    check_val("rst_grant", {30'd0, grant}, 0);
    check_val("rst_busy",  {31'd0, busy}, 0);
    check_val("rst_ack",   {30'd0, ack1, ack0}, 0);
    check_val("rst_rdata", rdata0 | rdata1, 0);
    check_val("rst_maddr", mem_addr, 0);
    tick();

    // Port 0 aligned read of word 5.
    do_access(0, 1'b0, 32'h14, 32'h0);
    check_val("rd_rdata0", rdata0, 32'd25);
    check_val("rd_err0", {31'd0, err0}, 0);
    req[0] = 1'b0;
    tick();

    // Port 1 write then read back.
    do_access(1, 1'b1, 32'h08, 32'hDEADBEEF);
    check_val("wr_rdata1_held", rdata1, 0);
    req[1] = 1'b0;
    tick();
    do_access(1, 1'b0, 32'h08, 32'h0);
    check_val("rd_back_rdata1", rdata1, 32'hDEADBEEF);
    req[1] = 1'b0;
    tick();

    // Misaligned write from port 0 is rejected.
    do_access(0, 1'b1, 32'h0A, 32'hCAFEF00D);
    check_val("mis_err0", {31'd0, err0}, 1);
    check_val("mis_rdata0", rdata0, 0);
    req[0] = 1'b0;
    tick();
    check_val("mis_word2", mem[2], 32'hDEADBEEF);

    // Reset lands while a write is in ACCESS.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h12345678;
    tick();
    check_val("rst_acc_busy", {31'd0, busy}, 1);
    Reset = 1'b1; req[0] = 1'b0;
    #1;
    check_val("rst_acc_mem_rw", {31'd0, mem_rw}, 0);
    tick();
    Reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (ack0) seen++;
      tick();
    end
    check_val("rst_acc_no_ack", seen, 0);
    check_val("rst_acc_rdata1", rdata1, 0);
    check_val("rst_acc_word4", mem[4], 32'd16);

    // Lone port 1 request after reset is granted immediately.
    do_access(1, 1'b0, 32'h0C, 32'h0);
    check_val("p1_rdata1", rdata1, 32'd9);
    req[1] = 1'b0;
    tick();

    // Continuous dual requests: round-robin DUT and fixed-priority DUT side by side.
    Reset = 1'b1;
    tick();
    r = cyc;
    Reset = 1'b0;
    req = 2'b11; we = 2'b00; addr[0] = 32'h14; addr[1] = 32'h18;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      c = cyc - r;
      if (ack0) n0++;
      if (ack1) n1++;
      check_val("fix_grant", {30'd0, grant_f},
                {30'd0, ((c >= 1 && (c - 1) % 3 == 0) || (c >= 2 && (c - 2) % 3 == 0)) ? 2'b01 : 2'b00});
      check_val("fix_busy", {31'd0, busy_f},
                {31'd0, ((c >= 1 && (c - 1) % 3 == 0) || (c >= 2 && (c - 2) % 3 == 0))});
      check_val("fix_ack0", {31'd0, ack0_f}, {31'd0, (c >= 2 && (c - 2) % 3 == 0)});
      check_val("fix_ack1", {31'd0, ack1_f}, 0);
      check_val("fix_err", {30'd0, err1_f, err0_f}, 0);
      check_val("fix_rdata1", rdata1_f, 0);
      if (c >= 2) check_val("fix_rdata0", rdata0_f, 32'd25);
    end
    check_val("rr_acks0", n0, 4);
    check_val("rr_acks1", n1, 4);
    req = 2'b00;
    tick();
    tick();

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(199) == 0) Reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 0) ? ack0 : ack1;
        if (drop_nxt[p]) begin
          req[p] = 1'b0;
          drop_nxt[p] = 1'b0;
        end else if (req[p] && ackp) begin
          if ($urandom_range(1) == 1) req[p] = 1'b0;
          else drop_nxt[p] = 1'b1;
        end else if (!req[p] && $urandom_range(3) == 0) begin
          req[p]   = 1'b1;
          we[p]    = ($urandom_range(1) == 1);
          addr[p]  = {25'd0, 5'($urandom_range(31)), 2'b00};
          if ($urandom_range(7) == 0) addr[p][1:0] = 2'($urandom_range(3, 1));
          wdata[p] = $urandom;
        end
      end
    end

    Reset = 1'b0; req = 2'b00;
    repeat (4) tick();
    for (int i = 0; i < 32; i++) check_val("mem_final", mem[i], m_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
